// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Parses short ASCII line commands arriving from the UART receiver:
//   L<hh><CR|LF>  sets the LED register to the low 6 bits of hh and replies "K\r\n"
//   R<CR|LF>      replies with the LED register as two uppercase hex chars + "\r\n"
//   anything else is swallowed up to the next terminator, then "E\r\n" is sent
//   and cmd_error pulses.
// A partial command that sits idle for TIMEOUT_CYCLES clocks is silently dropped.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   rx_data, rx_valid   received byte and its single-cycle strobe
//   tx_data, tx_valid,  reply byte stream (valid/ready, no retraction)
//   tx_ready
//   led_value           6-bit LED register
//   cmd_error           one-cycle pulse on a command error or a dropped byte
//   busy                high while reply bytes are pending
module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [5:0] led_value,
  output logic       cmd_error,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GOT_L, S_GOT_H1, S_GOT_H2, S_GOT_R, S_DISCARD, S_RESPOND
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [1:0]      nib_hi;          // only the bits that survive into led_value
  logic [3:0]      nib_lo;
  logic [7:0]      rbuf [4];
  logic [1:0]      idx;
  logic [2:0]      len;

  logic            load_reply, store_hi, store_lo, led_load, err_set;
  logic [7:0]      reply [4];
  logic [2:0]      reply_len;
  logic            timed, expire, tx_fire, last;
  logic [3:0]      hex_nib;

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  // 'A'/'a' have low nibble 1, so +9 maps letters onto 10..15
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    else return b[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else return 8'h37 + {4'h0, n};
  endfunction

  assign busy     = (state == S_RESPOND);
  assign tx_valid = (state == S_RESPOND);
  assign tx_fire  = tx_valid && tx_ready;
  assign last     = ({1'b0, idx} == (len - 3'd1));
  assign hex_nib  = hex_val(rx_data);
  assign timed    = (state == S_GOT_L) || (state == S_GOT_H1) || (state == S_GOT_H2) ||
                    (state == S_GOT_R) || (state == S_DISCARD);
  // an incoming byte on the expiry edge takes priority over the timeout
  assign expire   = timed && !rx_valid && (cnt == CNT_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and datapath control strobes
  always_comb begin
    state_next = state;
    load_reply = 1'b0;
    store_hi   = 1'b0;
    store_lo   = 1'b0;
    led_load   = 1'b0;
    err_set    = 1'b0;
    reply[0]   = 8'h4B;
    reply[1]   = 8'h0D;
    reply[2]   = 8'h0A;
    reply[3]   = 8'h00;
    reply_len  = 3'd3;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h4C || rx_data == 8'h6C)      state_next = S_GOT_L;
          else if (rx_data == 8'h52 || rx_data == 8'h72) state_next = S_GOT_R;
          else if (is_term(rx_data))                     state_next = S_IDLE;
          else                                           state_next = S_DISCARD;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_GOT_L: begin
        if (rx_valid) begin
          if (is_hex(rx_data)) begin
            state_next = S_GOT_H1;
            store_hi   = 1'b1;
          end else begin
            state_next = S_DISCARD;
          end
        end else begin
          state_next = state;
        end
      end
      S_GOT_H1: begin
        if (rx_valid) begin
          if (is_hex(rx_data)) begin
            state_next = S_GOT_H2;
            store_lo   = 1'b1;
          end else begin
            state_next = S_DISCARD;
          end
        end else begin
          state_next = state;
        end
      end
      S_GOT_H2: begin
        if (rx_valid) begin
          if (is_term(rx_data)) begin
            state_next = S_RESPOND;
            load_reply = 1'b1;
            led_load   = 1'b1;
          end else begin
            state_next = S_DISCARD;
          end
        end else begin
          state_next = state;
        end
      end
      S_GOT_R: begin
        if (rx_valid) begin
          if (is_term(rx_data)) begin
            state_next = S_RESPOND;
            load_reply = 1'b1;
            reply[0]   = to_ascii({2'b00, led_value[5:4]});
            reply[1]   = to_ascii(led_value[3:0]);
            reply[2]   = 8'h0D;
            reply[3]   = 8'h0A;
            reply_len  = 3'd4;
          end else begin
            state_next = S_DISCARD;
          end
        end else begin
          state_next = state;
        end
      end
      S_DISCARD: begin
        if (rx_valid && is_term(rx_data)) begin
          state_next = S_RESPOND;
          load_reply = 1'b1;
          err_set    = 1'b1;
          reply[0]   = 8'h45;
        end else begin
          state_next = state;
        end
      end
      S_RESPOND: begin
        // bytes cannot be parsed while a reply is outstanding
        if (rx_valid) err_set = 1'b1;
        else          err_set = 1'b0;
        if (tx_fire && last) state_next = S_IDLE;
        else                 state_next = S_RESPOND;
      end
      default: state_next = S_IDLE;
    endcase
    if (expire) state_next = S_IDLE;
    else        state_next = state_next;
  end

  // Partial-command idle timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cnt <= '0;
    else if (rx_valid || !timed || expire) cnt <= '0;
    else                                cnt <= cnt + 1'b1;
  end

  // Command operands, LED register and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_hi    <= 2'd0;
      nib_lo    <= 4'd0;
      led_value <= 6'd0;
      cmd_error <= 1'b0;
    end else begin
      if (store_hi) nib_hi <= hex_nib[1:0];
      if (store_lo) nib_lo <= hex_nib;
      if (led_load) led_value <= {nib_hi, nib_lo};
      cmd_error <= err_set;
    end
  end

  // Reply buffer and the byte currently offered to the transmitter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rbuf[i] <= 8'h00;
      idx     <= 2'd0;
      len     <= 3'd0;
      tx_data <= 8'h00;
    end else if (load_reply) begin
      for (int i = 0; i < 4; i++) rbuf[i] <= reply[i];
      idx     <= 2'd0;
      len     <= reply_len;
      tx_data <= reply[0];
    end else if (tx_fire && !last) begin
      idx     <= idx + 2'd1;
      tx_data <= rbuf[idx + 2'd1];
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [5:0] led_value;
  logic       cmd_error;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] txq[$];
  int         busy_n = 0;
  int         err_n  = 0;

  uart_cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .led_value(led_value), .cmd_error(cmd_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observe transfers, busy cycles and error pulses mid-cycle
  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (busy) busy_n++;
    if (cmd_error) err_n++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic clear_mon();
    txq.delete();
    busy_n = 0;
    err_n  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    wait_cycles(3);
    checks++; if (tx_valid !== 1'b0)  begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (led_value !== 6'h0) begin errors++; $display("FAIL reset_led got %h want 00", led_value); end
    rst = 1'b0;
    wait_cycles(2);
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL reset_cmd_error got %b want 0", cmd_error); end
  endtask

  task automatic test_l_cmd();
    clear_mon();
    send_byte(8'h4C); send_byte(8'h32); send_byte(8'h41); send_byte(8'h0D);
    checks++; if (led_value !== 6'h2A) begin errors++; $display("FAIL l2a_led got %h want 2a", led_value); end
    wait_cycles(6);
    checks++;
    if (txq.size() != 3 || txq[0] !== 8'h4B || txq[1] !== 8'h0D || txq[2] !== 8'h0A) begin
      errors++; $display("FAIL l2a_reply got n=%0d %h %h %h want n=3 4b 0d 0a", txq.size(), txq[0], txq[1], txq[2]);
    end
    checks++; if (busy_n != 3) begin errors++; $display("FAIL l2a_busy got %0d cycles want 3", busy_n); end
    checks++; if (err_n != 0)  begin errors++; $display("FAIL l2a_cmd_error got %0d pulses want 0", err_n); end
  endtask

  task automatic test_lower_and_read();
    clear_mon();
    send_byte(8'h6C); send_byte(8'h66); send_byte(8'h66); send_byte(8'h0D);
    wait_cycles(6);
    send_byte(8'h0A);
    wait_cycles(3);
    checks++; if (led_value !== 6'h3F) begin errors++; $display("FAIL lff_led got %h want 3f", led_value); end
    checks++;
    if (txq.size() != 3 || txq[0] !== 8'h4B) begin
      errors++; $display("FAIL lff_reply got n=%0d first %h want n=3 4b", txq.size(), txq[0]);
    end
    clear_mon();
    send_byte(8'h52); send_byte(8'h0D);
    wait_cycles(7);
    checks++;
    if (txq.size() != 4 || txq[0] !== 8'h33 || txq[1] !== 8'h46 || txq[2] !== 8'h0D || txq[3] !== 8'h0A) begin
      errors++; $display("FAIL r3f_reply got n=%0d %h %h %h %h want n=4 33 46 0d 0a", txq.size(), txq[0], txq[1], txq[2], txq[3]);
    end
    checks++; if (err_n != 0) begin errors++; $display("FAIL lf_ignored cmd_error got %0d want 0", err_n); end
  endtask

  task automatic test_bad_hex();
    clear_mon();
    send_byte(8'h4C); send_byte(8'h47); send_byte(8'h31); send_byte(8'h0D);
    checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL lg1_pulse_timing got %b want 1", cmd_error); end
    wait_cycles(6);
    checks++; if (led_value !== 6'h3F) begin errors++; $display("FAIL lg1_led got %h want 3f", led_value); end
    checks++;
    if (txq.size() != 3 || txq[0] !== 8'h45 || txq[1] !== 8'h0D || txq[2] !== 8'h0A) begin
      errors++; $display("FAIL lg1_reply got n=%0d %h %h %h want n=3 45 0d 0a", txq.size(), txq[0], txq[1], txq[2]);
    end
    checks++; if (err_n != 1) begin errors++; $display("FAIL lg1_cmd_error got %0d pulses want 1", err_n); end
  endtask

  task automatic test_reset_mid_reply();
    clear_mon();
    send_byte(8'h4C); send_byte(8'h32); send_byte(8'h41); send_byte(8'h0D);
    wait_cycles(2);
    checks++;
    if (txq.size() != 2 || txq[1] !== 8'h0D) begin
      errors++; $display("FAIL mid_pre_reset got n=%0d %h want n=2 0d", txq.size(), txq[1]);
    end
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0)  begin errors++; $display("FAIL mid_tx_valid got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (led_value !== 6'h0) begin errors++; $display("FAIL mid_led got %h want 00", led_value); end
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(1);
    clear_mon();
    send_byte(8'h52); send_byte(8'h0D);
    wait_cycles(7);
    checks++;
    if (txq.size() != 4 || txq[0] !== 8'h30 || txq[1] !== 8'h30 || txq[2] !== 8'h0D || txq[3] !== 8'h0A) begin
      errors++; $display("FAIL mid_r_reply got n=%0d %h %h %h %h want n=4 30 30 0d 0a", txq.size(), txq[0], txq[1], txq[2], txq[3]);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_byte(8'h4C); send_byte(8'h34);
    wait_cycles(20);
    checks++; if (txq.size() != 0) begin errors++; $display("FAIL to_silent got %0d bytes want 0", txq.size()); end
    send_byte(8'h52); send_byte(8'h0D);
    wait_cycles(7);
    checks++;
    if (txq.size() != 4 || txq[0] !== 8'h30 || txq[1] !== 8'h30 || txq[2] !== 8'h0D || txq[3] !== 8'h0A) begin
      errors++; $display("FAIL to_r_reply got n=%0d %h %h %h %h want n=4 30 30 0d 0a", txq.size(), txq[0], txq[1], txq[2], txq[3]);
    end
    checks++; if (err_n != 0)         begin errors++; $display("FAIL to_cmd_error got %0d want 0", err_n); end
    checks++; if (led_value !== 6'h0) begin errors++; $display("FAIL to_led got %h want 00", led_value); end
  endtask

  task automatic test_stall();
    clear_mon();
    tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h0D);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h30) begin
        errors++; $display("FAIL stall_hold cycle %0d got valid=%b data=%h want 1 30", i, tx_valid, tx_data);
      end
      rx_data  = 8'h41;
      rx_valid = (i == 3);
      wait_cycles(1);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wait_cycles(7);
    checks++;
    if (txq.size() != 4 || txq[0] !== 8'h30 || txq[1] !== 8'h30 || txq[2] !== 8'h0D || txq[3] !== 8'h0A) begin
      errors++; $display("FAIL stall_reply got n=%0d %h %h %h %h want n=4 30 30 0d 0a", txq.size(), txq[0], txq[1], txq[2], txq[3]);
    end
    checks++; if (err_n != 1) begin errors++; $display("FAIL stall_drop_error got %0d pulses want 1", err_n); end
  endtask

  initial begin
    test_reset();
    test_l_cmd();
    test_lower_and_read();
    test_bad_hex();
    test_reset_mid_reply();
    test_timeout();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its received-byte strobe.
- Parses short ASCII line commands and drives the 6-bit LED register.
- Returns ASCII replies to the UART transmitter over a valid/ready byte interface.
- Replaces the receiver's direct byte-to-LED path with a command protocol that has error handling and a timeout.

Parameters:
- TIMEOUT_CYCLES, 2700000: idle clocks allowed inside a partial command before it is silently discarded (100 ms at 27 MHz).

Ports:
- clk, input, 1: system clock, 27 MHz.
- rst, input, 1: asynchronous, active-high reset.
- rx_data, input, 8: received byte. Valid only when rx_valid=1.
- rx_valid, input, 1: single-cycle strobe, one per received byte.
- tx_data, output, 8: reply byte to the transmitter.
- tx_valid, output, 1: tx_data holds a reply byte.
- tx_ready, input, 1: the transmitter accepts tx_data this cycle.
- led_value, output, 6: LED register, active-high value.
- cmd_error, output, 1: one-cycle pulse on a command error or a dropped byte.
- busy, output, 1: high while reply bytes are pending.

Behaviour:
- Reset (asynchronous, any time, including mid-reply):
  - State goes to IDLE.
  - led_value=0, tx_valid=0, tx_data=0x00, cmd_error=0, busy=0.
  - Timeout counter=0.
  - Any pending reply is discarded.
- Definitions:
  - Terminator (TERM) = 0x0D or 0x0A.
  - Command letters are case-insensitive.
  - Hex digits are 0-9, A-F, a-f.
- States and transitions (each step happens on a cycle with rx_valid=1):
  - IDLE:
    - 'L'/'l' -> GOT_L.
    - 'R'/'r' -> GOT_R.
    - TERM is ignored (absorbs the second byte of CRLF).
    - Any other byte -> DISCARD.
  - GOT_L: hex -> GOT_H1, storing the high nibble. Else -> DISCARD.
  - GOT_H1: hex -> GOT_H2, storing the low nibble. Else -> DISCARD.
  - GOT_H2:
    - TERM -> RESPOND with "K",0x0D,0x0A.
    - On the same edge, led_value <= byte[5:0]; bits [7:6] are dropped.
    - Any other byte -> DISCARD.
  - GOT_R: TERM -> RESPOND with two uppercase hex chars of {2'b00,led_value}, then 0x0D,0x0A. Else -> DISCARD.
  - DISCARD: TERM -> RESPOND with "E",0x0D,0x0A, and cmd_error pulses in the cycle after the TERM edge. Non-TERM bytes are ignored.
  - RESPOND: sends the reply buffer (3 or 4 bytes) in order. After the last byte is accepted -> IDLE on the same edge.
- Reply latency and handshake:
  - If the TERM is accepted on edge N, tx_valid=1 with the first reply byte from edge N onward, i.e. visible in cycle N+1.
  - A byte is transferred on a clock edge where tx_valid=1 and tx_ready=1.
  - tx_data and tx_valid stay stable until that transfer; there is no retraction.
  - After each transfer, the next byte is presented in the following cycle, or tx_valid drops after the last byte.
  - busy equals the RESPOND state.
- Bytes arriving during RESPOND:
  - An rx_valid byte during RESPOND is dropped.
  - cmd_error pulses for one cycle.
  - Parser state is unaffected.
- Timeout:
  - The counter clears on every rx_valid.
  - It increments each cycle in GOT_L, GOT_H1, GOT_H2, GOT_R and DISCARD.
  - When it reaches TIMEOUT_CYCLES-1: -> IDLE, counter=0, no reply, no cmd_error, led_value unchanged.
  - The counter is held at 0 in IDLE and RESPOND.
- Simultaneous events:
  - rx_valid on the same edge as a timeout expiry: the byte wins and the counter clears.
  - rx_valid on the same edge as the final tx transfer: the byte is dropped with cmd_error. RESPOND still exits to IDLE.
- led_value changes only on a completed, valid L command.
- Hex-to-ASCII conversion for R replies:
  - Nibble 0-9 -> 0x30+n.
  - Nibble 10-15 -> 0x37+n.
- Widths:
  - The timeout counter is sized by $clog2(TIMEOUT_CYCLES).
  - The reply buffer is 4x8 bits, with a 2-bit index and a 3-bit length.

Test Plan:
- Send "L2A",0x0D with tx_ready=1. Required: led_value=0x2A on the CR edge; tx sequence 0x4B,0x0D,0x0A; busy high for exactly 3 transfers; cmd_error never pulses.
- Send "lff",0x0D,0x0A, then "R",0x0D, with tx_ready=1. Required: led_value=0x3F; the trailing LF is ignored; R reply is 0x33,0x46,0x0D,0x0A ("3F").
- Send "LG1",0x0D. Required: led_value unchanged; reply 0x45,0x0D,0x0A; exactly one cmd_error pulse.
- With TIMEOUT_CYCLES=16, send "L4", then idle for 20 cycles, then "R",0x0D. Required: silent return to IDLE after 16 cycles; R reply reflects the old LED value (0x30,0x30,0x0D,0x0A after reset).
- Send "R",0x0D while holding tx_ready=0 for 10 cycles, inject rx byte 0x41 mid-stall, then release tx_ready. Required: tx_data is stable at 0x30 during the stall; 0x41 is dropped with one cmd_error pulse; the reply completes intact.
- Assert rst for 1 cycle after the 2nd reply byte of "K\r\n". Required: tx_valid=0 and busy=0 immediately; led_value=0; a subsequent "R",0x0D returns "00\r\n".
